pll_freq_sequencer: RTL and testbench

- Control stage directly upstream of the PLL, in the refclk domain.
- Drives the PLL's `divn` and `brake` inputs.
- Accepts target-divider requests over a valid/ready handshake and slews `divn` toward the target in bounded steps, dwelling at each step.
- After the last step, waits for PLL lock and reports completion or timeout.
- Converts an external supply-droop indication into a bounded brake pulse, then resumes the ramp.

---
 rtl/pll_freq_sequencer_if.sv | 25 ++
 rtl/pll_freq_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_pll_freq_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_freq_sequencer_if.sv
// ============================================================================
// pll_freq_sequencer_if : target-divider request handshake (valid/ready)
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pll_freq_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_divn;

  modport master (
    output req_valid,
    output req_divn,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_divn,
    output req_ready
  );
endinterface

`default_nettype wire

// File: rtl/pll_freq_sequencer.sv
// ============================================================================
// pll_freq_sequencer : slews PLL divn toward requested targets, waits for lock,
//                      and converts supply-droop edges into bounded brake pulses
// Revision: 1.0
// ============================================================================
`default_nettype none

module pll_freq_sequencer #(
  parameter int DIVN_RESET   = 100,
  parameter int DIVN_MIN     = 8,
  parameter int DIVN_MAX     = 1023,
  parameter int STEP         = 1,
  parameter int HOLD_CYCLES  = 32,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int BRAKE_PULSE  = 4
) (
  input  logic                       refclk,
  input  logic                       resetn,
  pll_freq_sequencer_if.slave        req,
  input  logic                       droop,
  input  logic                       locked,
  output logic [15:0]                divn,
  output logic                       brake,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err
);

  // One counter serves hold, lock-wait and brake timing; size it for the largest.
  localparam int c_max_hl  = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int c_cnt_max = (c_max_hl > BRAKE_PULSE) ? c_max_hl : BRAKE_PULSE;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP      = 3'd1,
    S_HOLD      = 3'd2,
    S_WAIT_LOCK = 3'd3,
    S_BRAKE     = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [15:0]          r_divn, w_divn_nxt;
  logic [15:0]          r_target, w_target_nxt;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
  logic                 r_brake, w_brake_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_terr, w_terr_nxt;
  logic                 r_ready, w_ready_nxt;
  logic                 r_droop_d;

  logic                 w_droop_edge;
  logic                 w_accept;
  logic [15:0]          w_clamped;
  logic signed [16:0]   w_diff;
  logic [16:0]          w_mag;
  logic [16:0]          w_step;
  logic [15:0]          w_ramp_divn;
  logic                 w_cnt_last;

  assign w_droop_edge = droop & ~r_droop_d;
  assign w_accept     = req.req_valid & r_ready;
  assign w_cnt_last   = (r_cnt <= c_cnt_w'(1));

  assign w_clamped = (req.req_divn < 16'(DIVN_MIN)) ? 16'(DIVN_MIN) :
                     (req.req_divn > 16'(DIVN_MAX)) ? 16'(DIVN_MAX) :
                     req.req_divn;

  // 17-bit signed difference: no wrap near 0 or 65535, and the step never overshoots.
  assign w_diff      = $signed({1'b0, r_target}) - $signed({1'b0, r_divn});
  assign w_mag       = w_diff[16] ? 17'(-w_diff) : 17'(w_diff);
  assign w_step      = (w_mag > 17'(STEP)) ? 17'(STEP) : w_mag;
  assign w_ramp_divn = w_diff[16] ? (r_divn - w_step[15:0]) : (r_divn + w_step[15:0]);

  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_divn    <= 16'(DIVN_RESET);
      r_target  <= 16'(DIVN_RESET);
      r_cnt     <= '0;
      r_brake   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_terr    <= 1'b0;
      r_ready   <= 1'b0;
      r_droop_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_divn    <= w_divn_nxt;
      r_target  <= w_target_nxt;
      r_cnt     <= w_cnt_nxt;
      r_brake   <= w_brake_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_terr    <= w_terr_nxt;
      r_ready   <= w_ready_nxt;
      r_droop_d <= droop;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_divn_nxt   = r_divn;
    w_target_nxt = r_target;
    w_cnt_nxt    = r_cnt;
    w_brake_nxt  = r_brake;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_terr_nxt   = r_terr;

    if (w_droop_edge && (r_state != S_BRAKE)) begin
      // A request arriving on the droop edge is still latched; the brake runs first.
      if ((r_state == S_IDLE) && w_accept) begin
        w_target_nxt = w_clamped;
        w_busy_nxt   = 1'b1;
        w_terr_nxt   = 1'b0;
      end
      w_state_nxt = S_BRAKE;
      w_brake_nxt = 1'b1;
      w_cnt_nxt   = c_cnt_w'(BRAKE_PULSE);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_target_nxt = w_clamped;
            w_busy_nxt   = 1'b1;
            w_terr_nxt   = 1'b0;
            if (w_clamped == r_divn) begin
              w_state_nxt = S_WAIT_LOCK;
              w_cnt_nxt   = c_cnt_w'(LOCK_TIMEOUT);
            end else begin
              w_state_nxt = S_RAMP;
            end
          end
        end
        S_RAMP: begin
          w_divn_nxt  = w_ramp_divn;
          w_cnt_nxt   = c_cnt_w'(HOLD_CYCLES);
          w_state_nxt = S_HOLD;
        end
        S_HOLD: begin
          if (w_cnt_last) begin
            if (r_divn == r_target) begin
              w_state_nxt = S_WAIT_LOCK;
              w_cnt_nxt   = c_cnt_w'(LOCK_TIMEOUT);
            end else begin
              w_state_nxt = S_RAMP;
            end
          end else begin
            w_cnt_nxt = r_cnt - c_cnt_w'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (locked) begin
            if (r_divn != r_target) begin
              w_state_nxt = S_RAMP;
            end else begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = r_busy;
              w_busy_nxt  = 1'b0;
            end
          end else if (w_cnt_last) begin
            w_state_nxt  = S_IDLE;
            w_target_nxt = r_divn;
            w_done_nxt   = r_busy;
            w_busy_nxt   = 1'b0;
            if (r_busy) begin
              w_terr_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt - c_cnt_w'(1);
          end
        end
        S_BRAKE: begin
          if (w_cnt_last) begin
            w_brake_nxt = 1'b0;
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = c_cnt_w'(LOCK_TIMEOUT);
          end else begin
            w_cnt_nxt = r_cnt - c_cnt_w'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_brake_nxt = 1'b0;
        end
      endcase
    end

    w_ready_nxt = (w_state_nxt == S_IDLE);
  end

  assign divn          = r_divn;
  assign brake         = r_brake;
  assign busy          = r_busy;
  assign done          = r_done;
  assign timeout_err   = r_terr;
  assign req.req_ready = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_pll_freq_sequencer.sv
// ============================================================================
// tb_pll_freq_sequencer : directed checks of ramp, lock, timeout, droop, reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pll_freq_sequencer;

  logic        refclk = 1'b0;
  logic        resetn = 1'b0;
  logic        droop  = 1'b0;
  logic        locked = 1'b1;

  logic [15:0] divn1, divn4;
  logic        brake1, busy1, done1, terr1;
  logic        brake4, busy4, done4, terr4;

  int vectors     = 0;
  int miscompares = 0;
  int done4_count = 0;

  pll_freq_sequencer_if rq1 ();
  pll_freq_sequencer_if rq4 ();

  pll_freq_sequencer #(
    .STEP(1), .HOLD_CYCLES(4), .LOCK_TIMEOUT(16), .BRAKE_PULSE(4)
  ) dut (
    .refclk(refclk), .resetn(resetn), .req(rq1), .droop(droop), .locked(locked),
    .divn(divn1), .brake(brake1), .busy(busy1), .done(done1), .timeout_err(terr1)
  );

  pll_freq_sequencer #(
    .STEP(4), .HOLD_CYCLES(4), .LOCK_TIMEOUT(16), .BRAKE_PULSE(4)
  ) dut4 (
    .refclk(refclk), .resetn(resetn), .req(rq4), .droop(droop), .locked(locked),
    .divn(divn4), .brake(brake4), .busy(busy4), .done(done4), .timeout_err(terr4)
  );

  always #5 refclk = ~refclk;

  always @(posedge refclk) begin
    if (done4) done4_count++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int rises;
    rq1.req_valid = 1'b0; rq1.req_divn = 16'd0;
    rq4.req_valid = 1'b0; rq4.req_divn = 16'd0;

    // Reset values, and req_ready low for the first cycle after release
    tick(2);
    chk("rst_divn", divn1, 100);
    chk("rst_brake", brake1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_terr", terr1, 0);
    chk("rst_ready", rq1.req_ready, 0);
    resetn = 1'b1;
    chk("rel_ready0", rq1.req_ready, 0);
    tick(1);
    chk("rel_ready1", rq1.req_ready, 1);

    // Ramp 100 -> 103, one step every HOLD+1 = 5 cycles
    rq1.req_valid = 1'b1; rq1.req_divn = 16'd103;
    tick(1);
    rq1.req_valid = 1'b0;
    chk("acc_busy", busy1, 1);
    chk("acc_ready", rq1.req_ready, 0);
    chk("acc_divn", divn1, 100);
    tick(1);  chk("r1_101", divn1, 101);
    tick(4);  chk("r1_hold101", divn1, 101);
    tick(1);  chk("r1_102", divn1, 102);
    tick(5);  chk("r1_103", divn1, 103);
    tick(4);  chk("r1_nodone", done1, 0);
    tick(1);
    chk("r1_done", done1, 1);
    chk("r1_busy0", busy1, 0);
    chk("r1_ready", rq1.req_ready, 1);
    tick(1);  chk("r1_done_once", done1, 0);

    // Lock timeout: 103 -> 101, then 16 cycles in WAIT_LOCK
    locked = 1'b0;
    rq1.req_valid = 1'b1; rq1.req_divn = 16'd101;
    tick(1);
    rq1.req_valid = 1'b0;
    tick(1);  chk("to_102", divn1, 102);
    tick(5);  chk("to_101", divn1, 101);
    tick(19);
    chk("to_early_done", done1, 0);
    chk("to_early_busy", busy1, 1);
    tick(1);
    chk("to_done", done1, 1);
    chk("to_terr", terr1, 1);
    chk("to_busy", busy1, 0);
    tick(1);  chk("to_terr_sticky", terr1, 1);
    locked = 1'b1;
    rq1.req_valid = 1'b1; rq1.req_divn = 16'd101;
    tick(1);
    rq1.req_valid = 1'b0;
    chk("to_terr_clr", terr1, 0);
    chk("same_tgt_busy", busy1, 1);
    tick(1);  chk("same_tgt_done", done1, 1);

    // Mid-ramp droop at divn=104, a second edge during BRAKE is ignored
    rq1.req_valid = 1'b1; rq1.req_divn = 16'd110;
    tick(1);
    rq1.req_valid = 1'b0;
    tick(11); chk("dr_104", divn1, 104);
    tick(1);  droop = 1'b1;
    tick(1);
    chk("dr_brake_on", brake1, 1);
    chk("dr_divn_frz", divn1, 104);
    droop = 1'b0;
    tick(1);  droop = 1'b1;
    tick(1);  droop = 1'b0;
    tick(1);
    chk("dr_brake_last", brake1, 1);
    chk("dr_divn_frz2", divn1, 104);
    tick(1);
    chk("dr_brake_off", brake1, 0);
    chk("dr_busy", busy1, 1);
    tick(2);  chk("dr_resume_105", divn1, 105);
    tick(25); chk("dr_110", divn1, 110);
    tick(4);  chk("dr_nodone", done1, 0);
    tick(1);
    chk("dr_done", done1, 1);
    chk("dr_busy0", busy1, 0);
    tick(1);  chk("dr_done_once", done1, 0);

    // Droop edge and request on the same IDLE edge; droop then held high
    rq1.req_valid = 1'b1; rq1.req_divn = 16'd120; droop = 1'b1;
    tick(1);
    rq1.req_valid = 1'b0;
    chk("se_busy", busy1, 1);
    chk("se_brake", brake1, 1);
    chk("se_divn", divn1, 110);
    tick(3);  chk("se_brake4", brake1, 1);
    tick(1);  chk("se_brake_off", brake1, 0);
    tick(2);  chk("se_111", divn1, 111);
    tick(45); chk("se_120", divn1, 120);
    tick(5);  chk("se_done", done1, 1);
    rises = 0;
    for (int i = 0; i < 43; i++) begin
      tick(1);
      if (brake1) rises++;
    end
    chk("se_single_brake", rises, 0);
    droop = 1'b0;

    // STEP=4 instance: idle droops gave no done; ramp down without overshoot
    tick(2);
    chk("s4_idle_dones", done4_count, 0);
    chk("s4_idle_divn", divn4, 100);
    chk("s4_idle_terr", terr4, 0);
    rq4.req_valid = 1'b1; rq4.req_divn = 16'd90;
    tick(1);
    rq4.req_valid = 1'b0;
    tick(1);  chk("s4_96", divn4, 96);
    tick(5);  chk("s4_92", divn4, 92);
    tick(5);  chk("s4_90", divn4, 90);
    tick(5);
    chk("s4_done", done4, 1);
    chk("s4_no_under", divn4, 90);

    rq4.req_valid = 1'b1; rq4.req_divn = 16'd2;
    tick(1);
    rq4.req_valid = 1'b0;
    n = 0;
    while (!done4 && n < 400) begin tick(1); n++; end
    chk("clamp_lo_done", done4, 1);
    chk("clamp_lo", divn4, 8);

    tick(1);
    rq4.req_valid = 1'b1; rq4.req_divn = 16'd2000;
    tick(1);
    rq4.req_valid = 1'b0;
    n = 0;
    while (!done4 && n < 2000) begin tick(1); n++; end
    chk("clamp_hi_done", done4, 1);
    chk("clamp_hi", divn4, 1023);

    // Reset during HOLD
    tick(1);
    rq1.req_valid = 1'b1; rq1.req_divn = 16'd125;
    tick(1);
    rq1.req_valid = 1'b0;
    tick(3);  chk("mr_121", divn1, 121);
    resetn = 1'b0;
    #1;
    chk("mr_divn", divn1, 100);
    chk("mr_busy", busy1, 0);
    chk("mr_ready", rq1.req_ready, 0);
    tick(1);
    resetn = 1'b1;
    chk("mr_ready_rel", rq1.req_ready, 0);
    tick(1);  chk("mr_ready_1", rq1.req_ready, 1);

    // Reset during BRAKE drops the brake at once
    droop = 1'b1;
    tick(1);  chk("mb_brake", brake1, 1);
    droop = 1'b0;
    tick(1);
    resetn = 1'b0;
    #1;
    chk("mb_brake_drop", brake1, 0);
    tick(1);
    resetn = 1'b1;
    tick(1);
    chk("mb_brake_after", brake1, 0);
    chk("mb_ready", rq1.req_ready, 1);
    chk("mb_divn", divn1, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
